prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_word_asm.sv | 43 ++++
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - state encoding and stream constants shared by the program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LEN_CHK,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int          HDR_BYTES         = 2;
  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - little-endian byte-to-word shift register with a byte counter.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          byte_en,
  input  logic [7:0]                    byte_data,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_full
);

  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
  logic [1:0]                  cnt_q, cnt_d;

  // Shifting in at the top leaves the first byte of a word in bits [7:0].
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_en) begin
      word_d = {byte_data, word_q[8*BYTES_PER_WORD-1:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_data = word_q;
  assign word_full = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader writing a length-prefixed byte image into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int LEN_W = 8 * HDR_BYTES;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               accept, clear, word_full;
  logic [31:0]        word_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept     = byte_valid && byte_ready;

  loader_word_asm u_word_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .byte_en   (accept && (state_q == S_DATA)),
    .byte_data (byte_data),
    .word_data (word_data),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    clear      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          clear      = 1'b1;
          word_cnt_d = '0;
          addr_d     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_LO: if (accept) begin
        len_d[7:0] = byte_data;
        state_d    = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        len_d[LEN_W-1:8] = byte_data;
        state_d          = S_LEN_CHK;
      end
      S_LEN_CHK: begin
        if ((len_q == '0) || (32'(len_q) > 32'(DEPTH_WORDS))) state_d = S_ERR;
        else                                                   state_d = S_DATA;
      end
      S_DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q ^ byte_data;
`endif
        if (word_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
        addr_d     = addr_q + 32'(BYTES_PER_WORD);
        if (word_cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (accept) begin
        state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_data;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_reset  = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader.
`timescale 1ns/1ps
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  logic [63:0] obs_q[$];
  int          we_count = 0;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      obs_q.push_back({imem_addr, imem_wdata});
      we_count <= we_count + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          obs_rd = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  csum;
  logic [31:0] exp_addr;
  logic [31:0] img[64];
  int          snap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        step(1);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      step(1);
      n++;
    end
    step(1);
    byte_valid = 1'b0;
    if (n >= 50) check("byte_accept_timeout", 64'(n), 64'(0));
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      csum = csum ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gaps);
    end
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic send_header(input logic [15:0] n);
    csum     = 8'h00;
    exp_addr = 32'h0;
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
  endtask

  task automatic load_image(input logic [15:0] n, input bit gaps);
    send_header(n);
    for (int k = 0; k < int'(n); k++) send_word(img[k], gaps);
  endtask

  task automatic finish_ok(input string tag);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 1'b0);
`else
    step(1);
`endif
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
  endtask

  task automatic drain(input string tag);
    int t;
    logic [63:0] e;
    t = 0;
    while (obs_q.size() < obs_rd + exp_q.size() && t < 50) begin
      step(1);
      t++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        check({tag, "_write"}, obs_q[obs_rd], e);
        obs_rd++;
      end else begin
        check({tag, "_missing_write"}, 64'hx, e);
      end
    end
    check({tag, "_write_count"}, 64'(obs_q.size()), 64'(obs_rd));
    obs_rd = obs_q.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    step(3);
    check("rst_byte_ready", 64'(byte_ready), 64'(0));
    check("rst_imem_we",    64'(imem_we),    64'(0));
    check("rst_imem_addr",  64'(imem_addr),  64'(32'h0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(32'h0));
    check("rst_cpu_reset",  64'(cpu_reset),  64'(1));
    check("rst_done",       64'(done),       64'(0));
    check("rst_error",      64'(error),      64'(0));
    reset = 1'b0;
    step(2);

    // Basic two-word load with exact write / done timing
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    pulse_start();
    load_image(16'd2, 1'b0);
    check("t1_we_t1",    64'(imem_we),    64'(1));
    check("t1_addr_t1",  64'(imem_addr),  64'(32'h4));
    check("t1_wdata_t1", 64'(imem_wdata), 64'(32'h0010_0093));
    check("t1_done_t1",  64'(done),       64'(0));
    finish_ok("t1");
    drain("t1");

    // Length errors: N=0 then N=65
    snap = we_count;
    pulse_start();
    check("t2_restart_cpu_reset", 64'(cpu_reset), 64'(1));
    check("t2_restart_done",      64'(done),       64'(0));
    send_header(16'd0);
    check("t2a_error_early", 64'(error), 64'(0));
    step(1);
    check("t2a_error",      64'(error),      64'(1));
    check("t2a_cpu_reset",  64'(cpu_reset),  64'(1));
    check("t2a_byte_ready", 64'(byte_ready), 64'(0));
    pulse_start();
    check("t2b_error_cleared", 64'(error), 64'(0));
    send_header(16'd65);
    step(1);
    check("t2b_error",      64'(error),      64'(1));
    check("t2b_cpu_reset",  64'(cpu_reset),  64'(1));
    check("t2b_byte_ready", 64'(byte_ready), 64'(0));
    step(3);
    check("t2_no_writes", 64'(we_count - snap), 64'(0));
    drain("t2");

    // 16-word image, gap-free then with random valid gaps
    for (int k = 0; k < 16; k++) img[k] = $urandom;
    pulse_start();
    load_image(16'd16, 1'b0);
    finish_ok("t3a");
    drain("t3a");
    snap = we_count;
    pulse_start();
    load_image(16'd16, 1'b1);
    finish_ok("t3b");
    drain("t3b");
    check("t3b_pulses", 64'(we_count - snap), 64'(16));

    // Reset after six data bytes
    pulse_start();
    send_header(16'd2);
    send_word(img[0], 1'b0);
    send_byte(img[1][7:0], 1'b0);
    send_byte(img[1][15:8], 1'b0);
    reset = 1'b1;
    step(1);
    check("t4_byte_ready", 64'(byte_ready), 64'(0));
    check("t4_cpu_reset",  64'(cpu_reset),  64'(1));
    check("t4_imem_addr",  64'(imem_addr),  64'(32'h0));
    check("t4_imem_wdata", 64'(imem_wdata), 64'(32'h0));
    reset = 1'b0;
    step(3);
    drain("t4_partial");
    img[0] = 32'hA5A5_0001; img[1] = 32'h5A5A_0002; img[2] = 32'h1234_5678;
    pulse_start();
    load_image(16'd3, 1'b0);
    finish_ok("t4_reload");
    drain("t4_reload");

    // start during DATA is ignored; start in DONE restarts
    pulse_start();
    send_header(16'd1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    pulse_start();
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    csum = 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    finish_ok("t5a");
    drain("t5a");
    pulse_start();
    check("t5b_cpu_reset",  64'(cpu_reset),  64'(1));
    check("t5b_done",       64'(done),       64'(0));
    check("t5b_byte_ready", 64'(byte_ready), 64'(1));
    img[0] = 32'hCAFE_F00D; img[1] = 32'h0BAD_C0DE;
    load_image(16'd2, 1'b0);
    finish_ok("t5b");
    drain("t5b");

`ifdef LOADER_CHECKSUM_EN
    // Trailing checksum byte: good then bad
    pulse_start();
    send_header(16'd1);
    send_word(32'h0804_0201, 1'b0);
    send_byte(8'h0F, 1'b0);
    check("t6a_done",  64'(done),  64'(1));
    check("t6a_error", 64'(error), 64'(0));
    drain("t6a");
    pulse_start();
    send_header(16'd1);
    send_word(32'h0804_0201, 1'b0);
    send_byte(8'h0E, 1'b0);
    check("t6b_error",     64'(error),     64'(1));
    check("t6b_done",      64'(done),      64'(0));
    check("t6b_cpu_reset", 64'(cpu_reset), 64'(1));
    drain("t6b");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
